// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Holds the FSM encoding and the prefetch FIFO entry layout {pc, instr}.
package fetch_pkg;

   localparam int          INSTR_W          = 32;
   localparam int          ADDR_W           = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fifo_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of {pc, instr} entries; flush beats push and pop.
// Storage is not reset, only pointers and occupancy.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  fifo_entry_t            din,
   output fifo_entry_t            head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int             PW   = $clog2(DEPTH);
   localparam logic [PW:0]    FULL = (PW + 1)'(DEPTH);

   fifo_entry_t   mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_push = push && !flush && (count < FULL);
   assign do_pop  = pop && !flush && (count != '0);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch PC owner and sequencer in front of a combinational instruction memory.
// Captures each word with its PC into a prefetch FIFO and serves decode via valid/ready.
module imem_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int          DEPTH     = 4,
   parameter int          MEM_WORDS = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   fetch_en,
   output logic [ADDR_W-1:0]      imem_addr,
   input  logic [INSTR_W-1:0]     imem_instr,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [INSTR_W-1:0]     out_instr,
   output logic [ADDR_W-1:0]      out_pc,
   input  logic                   redirect_valid,
   input  logic [ADDR_W-1:0]      redirect_pc,
   output logic                   fetch_fault,
   output logic [$clog2(DEPTH):0] fifo_count
);

   localparam int                  CW       = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0]       FULL     = CW'(DEPTH);
   localparam logic [ADDR_W-1:0]   PC_LIMIT = ADDR_W'(4 * MEM_WORDS);

   fetch_state_t      state, state_nxt;
   logic [ADDR_W-1:0] fetch_pc, pc_nxt;
   logic              push;
   logic              pop;
   logic              in_range;
   fifo_entry_t       din;
   fifo_entry_t       head;

   assign imem_addr   = fetch_pc;
   assign in_range    = fetch_pc < PC_LIMIT;
   assign fetch_fault = (state == FAULT);
   assign out_valid   = (fifo_count != '0);
   assign pop         = out_valid && out_ready && !redirect_valid;
   assign din         = '{pc: fetch_pc, instr: imem_instr};
   assign out_instr   = out_valid ? head.instr : '0;
   assign out_pc      = out_valid ? head.pc    : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= RUN;
         fetch_pc <= RESET_PC;
      end else begin
         state    <= state_nxt;
         fetch_pc <= pc_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = fetch_pc;
      push      = 1'b0;
      if (redirect_valid) begin
         state_nxt = RUN;
         pc_nxt    = redirect_pc & 32'hFFFF_FFFC;
      end else if (state == RUN && fetch_en) begin
         // Range check takes precedence so an out-of-range word never enters the FIFO.
         if (!in_range) begin
            state_nxt = FAULT;
         end else if (fifo_count < FULL) begin
            push   = 1'b1;
            pc_nxt = fetch_pc + 32'd4;
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .din   (din),
      .head  (head),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Randomized + directed bench for imem_fetch_ctrl against a queue-based fetch model.
module tb_imem_fetch_ctrl;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam int          DEPTH     = 4;
   localparam int          MEM_WORDS = 64;
   localparam logic [31:0] LIMIT     = 32'(4 * MEM_WORDS);

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_fault;
   logic [2:0]  fifo_count;

   int n_checks = 0;
   int n_errors = 0;

   logic [63:0] mq [$];
   logic [31:0] mpc;
   logic        mfault;

   always #5 clk = ~clk;

   assign imem_instr = imem_addr ^ 32'hA5A5_0000;

   imem_fetch_ctrl #(
      .RESET_PC  (RESET_PC),
      .DEPTH     (DEPTH),
      .MEM_WORDS (MEM_WORDS)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_en       (fetch_en),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_fault    (fetch_fault),
      .fifo_count     (fifo_count)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Compare every output against the model, then advance the model over one edge.
   task automatic step();
      logic do_pop, do_push;
      #1;
      chk("imem_addr", {32'h0, imem_addr}, {32'h0, mpc});
      chk("count", {61'h0, fifo_count}, 64'(mq.size()));
      chk("valid", {63'h0, out_valid}, {63'h0, mq.size() != 0});
      chk("fault", {63'h0, fetch_fault}, {63'h0, mfault});
      if (mq.size() != 0) chk("head", {out_pc, out_instr}, mq[0]);
      else                chk("head_empty", {out_pc, out_instr}, 64'h0);
      if (!rst_n) begin
         mq.delete(); mpc = RESET_PC; mfault = 1'b0;
      end else if (redirect_valid) begin
         mq.delete(); mpc = {redirect_pc[31:2], 2'b00}; mfault = 1'b0;
      end else begin
         do_pop  = (mq.size() != 0) && out_ready;
         do_push = !mfault && fetch_en && (mq.size() < DEPTH) && (mpc < LIMIT);
         if (!mfault && fetch_en && mpc >= LIMIT) mfault = 1'b1;
         if (do_pop) void'(mq.pop_front());
         if (do_push) begin
            mq.push_back({mpc, mpc ^ 32'hA5A5_0000});
            mpc = mpc + 32'd4;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; redirect_valid = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   logic [31:0] addr_frozen;

   initial begin
      rst_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      mq.delete(); mpc = 32'hDEAD_BEEF; mfault = 1'b0;
      @(posedge clk); #1;
      mpc = RESET_PC;
      do_reset();
      chk("rst_count", {61'h0, fifo_count}, 64'h0);
      chk("rst_addr", {32'h0, imem_addr}, {32'h0, RESET_PC});

      // Streaming fetch from reset.
      fetch_en = 1'b1; out_ready = 1'b1;
      step();
      chk("first_pc", {32'h0, out_pc}, 64'h0);
      chk("first_instr", {32'h0, out_instr}, 64'hA5A5_0000);
      chk("first_valid", {63'h0, out_valid}, 64'h1);
      for (int i = 1; i < 4; i++) begin
         step();
         chk("seq_pc", {32'h0, out_pc}, 64'(4 * i));
      end

      // Backpressure fills the FIFO and stalls the PC.
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) step();
      chk("full_count", {61'h0, fifo_count}, 64'd4);
      chk("stall_addr", {32'h0, imem_addr}, 64'h10);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_pc", {32'h0, out_pc}, 64'(4 * i));
         step();
      end

      // Redirect with three entries held.
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) step();
      chk("pre_redir_count", {61'h0, fifo_count}, 64'd3);
      redirect_valid = 1'b1; redirect_pc = 32'h22;
      step();
      chk("redir_count", {61'h0, fifo_count}, 64'h0);
      chk("redir_valid", {63'h0, out_valid}, 64'h0);
      chk("redir_addr", {32'h0, imem_addr}, 64'h20);
      redirect_valid = 1'b0; out_ready = 1'b1;
      step();
      chk("redir_pc", {32'h0, out_pc}, 64'h20);

      // Run off the end of memory.
      redirect_valid = 1'b1; redirect_pc = 32'hF0;
      step();
      redirect_valid = 1'b0;
      for (int i = 0; i < 6; i++) step();
      chk("fault_set", {63'h0, fetch_fault}, 64'h1);
      chk("fault_addr", {32'h0, imem_addr}, 64'h100);
      for (int i = 0; i < 3; i++) step();
      chk("fault_drained", {61'h0, fifo_count}, 64'h0);
      redirect_valid = 1'b1; redirect_pc = 32'h0;
      step();
      redirect_valid = 1'b0;
      chk("fault_clear", {63'h0, fetch_fault}, 64'h0);
      step();
      chk("resume_pc", {32'h0, out_pc}, 64'h0);

      // Push and pop together at count 2, then fetch_en off.
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) step();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("pp_count", {61'h0, fifo_count}, 64'd2);
      end
      fetch_en = 1'b0;
      addr_frozen = imem_addr;
      for (int i = 0; i < 3; i++) step();
      chk("en_off_count", {61'h0, fifo_count}, 64'h0);
      chk("en_off_addr", {32'h0, imem_addr}, {32'h0, addr_frozen});

      // Reset mid-stream; rst_n low without an edge must not change state.
      fetch_en = 1'b1; out_ready = 1'b0;
      for (int i = 0; i < 3; i++) step();
      rst_n = 1'b0;
      #2;
      chk("async_hold_count", {61'h0, fifo_count}, 64'd3);
      step();
      rst_n = 1'b1;
      chk("mid_rst_count", {61'h0, fifo_count}, 64'h0);
      chk("mid_rst_valid", {63'h0, out_valid}, 64'h0);
      chk("mid_rst_addr", {32'h0, imem_addr}, {32'h0, RESET_PC});

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         rst_n          = ($urandom_range(0, 99) >= 1);
         fetch_en       = ($urandom_range(0, 99) < 85);
         out_ready      = ($urandom_range(0, 99) < 65);
         redirect_valid = ($urandom_range(0, 99) < 4);
         redirect_pc    = $urandom_range(0, 32'h11F);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
